// File: rtl/sha3_pkg.sv
// sha3_pkg: shared constants, mode encodings, rate table and FSM state
// encoding for the multi-rate SHA-3 padder.
package sha3_pkg;

    localparam int unsigned MAX_RATE = 1152;
    localparam int unsigned CNT_W    = 6;     // holds 0..36 (IN_W=32, SHA3-224)

    localparam logic [7:0] PAD_START = 8'h06;
    localparam logic [7:0] PAD_END   = 8'h80;

    typedef enum logic [1:0] {
        MODE_224 = 2'd0,
        MODE_256 = 2'd1,
        MODE_384 = 2'd2,
        MODE_512 = 2'd3
    } sha3_mode_e;

    localparam int unsigned RATE [4] = '{1152, 1088, 832, 576};

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ABSORB = 3'd1,
        ST_PAD    = 3'd2,
        ST_FULL   = 3'd3,
        ST_DONE   = 3'd4
    } pad_state_e;

    // Number of message words that make up one rate block.
    function automatic int unsigned words_per_block(input logic [1:0] m, input int unsigned in_w);
        return RATE[m] / in_w;
    endfunction

    // Distance from the rate boundary to the bottom of the 1152-bit output.
    function automatic int unsigned rate_shift(input logic [1:0] m);
        return MAX_RATE - RATE[m];
    endfunction

endpackage

// File: rtl/sha3_padder_mr_pad_word.sv
// sha3_pad_word: combinational builder for one padded word.
//   data     : message word, first byte in the top byte lane
//   byte_num : valid bytes when is_last=1
//   is_last  : word is the final message word (insert 0x06 after valid bytes)
//   end_blk  : word is the final word of the block (OR 0x80 into low byte)
//   word_c   : resulting word
// With data=0, is_last=0 it produces the PAD zero word (or 0x80 word).
module sha3_pad_word
    import sha3_pkg::*;
#(
    parameter int unsigned IN_W = 64,
    parameter int unsigned BN_W = $clog2(IN_W / 8)
) (
    input  logic [IN_W-1:0] data,
    input  logic [BN_W-1:0] byte_num,
    input  logic            is_last,
    input  logic            end_blk,
    output logic [IN_W-1:0] word_c
);

    localparam int unsigned NB = IN_W / 8;

    logic [7:0] byte_v;

    // Byte lane i counts from the top of the word (first message byte).
    always_comb begin
        word_c = '0;
        byte_v = '0;
        for (int i = 0; i < NB; i++) begin
            byte_v = data[IN_W-1-8*i -: 8];
            if (is_last) begin
                if (BN_W'(i) < byte_num) begin
                    byte_v = data[IN_W-1-8*i -: 8];
                end else if (BN_W'(i) == byte_num) begin
                    byte_v = PAD_START;
                end else begin
                    byte_v = 8'h00;
                end
            end
            if (end_blk && (i == NB - 1)) begin
                byte_v = byte_v | PAD_END;
            end
            word_c[IN_W-1-8*i -: 8] = byte_v;
        end
    end

endmodule

// File: rtl/sha3_padder_mr.sv
// sha3_padder_mr: multi-rate SHA-3 input padder. Collects message words into
// a rate block, applies 0x06..0x80 domain padding and hands the left-aligned
// block to the permutation, stalling the user until f_ack.
//   clk, reset   : clock, synchronous active-high reset
//   in, in_ready : message word (first byte at top) and its valid
//   is_last      : final word; byte_num gives its valid byte count
//   mode         : 0..3 = SHA3-224/256/384/512, latched on first word
//   buffer_full  : user must hold the current word
//   out          : rate block in out[1151 -: rate], zeros below
//   out_ready    : out holds a complete block
//   f_ack        : permutation consumed the block
module sha3_padder_mr
    import sha3_pkg::*;
#(
    parameter int unsigned IN_W = 64,
    parameter int unsigned BN_W = $clog2(IN_W / 8)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [IN_W-1:0]     in,
    input  logic                in_ready,
    input  logic                is_last,
    input  logic [BN_W-1:0]     byte_num,
    input  logic [1:0]          mode,
    output logic                buffer_full,
    output logic [MAX_RATE-1:0] out,
    output logic                out_ready,
    input  logic                f_ack
);

    localparam logic [2:0] S_IDLE   = ST_IDLE;
    localparam logic [2:0] S_ABSORB = ST_ABSORB;
    localparam logic [2:0] S_PAD    = ST_PAD;
    localparam logic [2:0] S_FULL   = ST_FULL;
    localparam logic [2:0] S_DONE   = ST_DONE;

    localparam logic [MAX_RATE-1:0] ONES = '1;

    logic [2:0]          state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [MAX_RATE-1:0] buf_q, buf_d;
    logic [1:0]          mode_q, mode_d;
    logic                last_q, last_d;
    logic                out_ready_q, out_ready_d;
    logic                buffer_full_q, buffer_full_d;

    logic [1:0]          cur_mode;
    logic                blk_end;
    logic                accept;
    logic [IN_W-1:0]     pw_data;
    logic                pw_last;
    logic                pw_end;
    logic [IN_W-1:0]     pw_word;
    logic [MAX_RATE-1:0] shifted;

    // Datapath select: user word while absorbing, zero word while padding.
    always_comb begin
        cur_mode = (state_q == S_IDLE) ? mode : mode_q;
        blk_end  = (cnt_q == CNT_W'(words_per_block(cur_mode, IN_W) - 1));
        accept   = in_ready && !buffer_full_q
                   && ((state_q == S_IDLE) || (state_q == S_ABSORB));
        pw_data  = in;
        pw_last  = is_last;
        pw_end   = is_last && blk_end;
        if (state_q == S_PAD) begin
            pw_data = '0;
            pw_last = 1'b0;
            pw_end  = blk_end;
        end
    end

    sha3_pad_word #(
        .IN_W (IN_W),
        .BN_W (BN_W)
    ) u_pad_word (
        .data     (pw_data),
        .byte_num (byte_num),
        .is_last  (pw_last),
        .end_blk  (pw_end),
        .word_c   (pw_word)
    );

    // Shift register truncated to the rate; the first word ends at the top.
    always_comb begin
        shifted = {buf_q[MAX_RATE-IN_W-1:0], pw_word} & (ONES >> rate_shift(cur_mode));
    end

    // Next-state and output decode.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        buf_d   = buf_q;
        mode_d  = mode_q;
        last_d  = last_q;

        case (state_q)
            S_IDLE, S_ABSORB: begin
                if (accept) begin
                    if (state_q == S_IDLE) begin
                        mode_d = mode;
                    end
                    buf_d  = shifted;
                    cnt_d  = cnt_q + CNT_W'(1);
                    last_d = is_last;
                    if (blk_end) begin
                        state_d = S_FULL;
                    end else if (is_last) begin
                        state_d = S_PAD;
                    end else begin
                        state_d = S_ABSORB;
                    end
                end
            end
            S_PAD: begin
                buf_d = shifted;
                cnt_d = cnt_q + CNT_W'(1);
                if (blk_end) begin
                    state_d = S_FULL;
                end
            end
            S_FULL: begin
                if (f_ack) begin
                    buf_d   = '0;
                    cnt_d   = '0;
                    state_d = last_q ? S_DONE : S_ABSORB;
                end
            end
            S_DONE: begin
                state_d = S_DONE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        out_ready_d   = (state_d == S_FULL);
        buffer_full_d = (state_d == S_PAD) || (state_d == S_FULL) || (state_d == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            buf_q         <= '0;
            mode_q        <= 2'd0;
            last_q        <= 1'b0;
            out_ready_q   <= 1'b0;
            buffer_full_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            buf_q         <= buf_d;
            mode_q        <= mode_d;
            last_q        <= last_d;
            out_ready_q   <= out_ready_d;
            buffer_full_q <= buffer_full_d;
        end
    end

    // Left-align the rate-wide block in the 1152-bit output.
    always_comb begin
        out = buf_q << rate_shift(mode_q);
    end

    assign out_ready   = out_ready_q;
    assign buffer_full = buffer_full_q;

endmodule

// File: tb/tb_sha3_padder_mr.sv
// tb_sha3_padder_mr: directed self-checking bench for sha3_padder_mr (IN_W=64).
module tb_sha3_padder_mr;

    localparam int unsigned IN_W = 64;
    localparam int unsigned BN_W = 3;

    logic              clk = 1'b0;
    logic              reset;
    logic [IN_W-1:0]   in;
    logic              in_ready;
    logic              is_last;
    logic [BN_W-1:0]   byte_num;
    logic [1:0]        mode;
    logic              buffer_full;
    logic [1151:0]     out;
    logic              out_ready;
    logic              f_ack;

    int n_checks = 0;
    int n_fail   = 0;
    int n_acc    = 0;

    sha3_padder_mr #(
        .IN_W (IN_W),
        .BN_W (BN_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .in          (in),
        .in_ready    (in_ready),
        .is_last     (is_last),
        .byte_num    (byte_num),
        .mode        (mode),
        .buffer_full (buffer_full),
        .out         (out),
        .out_ready   (out_ready),
        .f_ack       (f_ack)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] dw(input int k);
        return 64'hA0A1_A2A3_A4A5_A6A7 ^ {8{8'(k)}};
    endfunction

    task automatic check(input string tag, input logic [1151:0] obs, input logic [1151:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        in       = '0;
        in_ready = 1'b0;
        is_last  = 1'b0;
        byte_num = '0;
        f_ack    = 1'b0;
        step();
        step();
        reset = 1'b0;
    endtask

    // Present a word and hold it until the padder takes it.
    task automatic send_word(input logic [63:0] d, input logic last, input logic [BN_W-1:0] bn);
        logic bf;
        logic ok;
        ok       = 1'b0;
        in       = d;
        in_ready = 1'b1;
        is_last  = last;
        byte_num = bn;
        for (int t = 0; t < 50; t++) begin
            bf = buffer_full;
            step();
            if (!bf) begin
                ok = 1'b1;
                n_acc++;
                break;
            end
        end
        in_ready = 1'b0;
        is_last  = 1'b0;
        check("send_accepted", 1152'(ok), 1152'(1'b1));
    endtask

    logic [1151:0] exp;
    logic [63:0]   w8;
    int            n;

    initial begin
        mode = 2'd0;
        do_reset();

        // Reset values
        check("rst_out_ready", 1152'(out_ready), 1152'(1'b0));
        check("rst_buffer_full", 1152'(buffer_full), 1152'(1'b0));
        check("rst_out", out, '0);

        // Empty message, SHA3-256: one last word with no valid bytes
        mode = 2'd1;
        send_word(64'hDEAD_BEEF_CAFE_F00D, 1'b1, 3'd0);
        check("empty_bf_in_pad", 1152'(buffer_full), 1152'(1'b1));
        check("empty_ordy_in_pad", 1152'(out_ready), 1152'(1'b0));
        n = 0;
        while (!out_ready && n < 40) begin
            step();
            n++;
        end
        check("empty_pad_cycles", 1152'(n), 1152'(16));
        exp = '0;
        exp[1151:1144] = 8'h06;
        exp[71:64]     = 8'h80;
        check("empty_block", out, exp);
        f_ack = 1'b1;
        step();
        f_ack = 1'b0;
        check("empty_done_ordy", 1152'(out_ready), 1152'(1'b0));
        check("empty_done_bf", 1152'(buffer_full), 1152'(1'b1));
        step();
        step();
        check("empty_done_hold_bf", 1152'(buffer_full), 1152'(1'b1));

        // 0x86 corner, SHA3-512: final data word also ends the block
        do_reset();
        mode  = 2'd3;
        f_ack = 1'b1;               // stray acks while absorbing are ignored
        for (int k = 0; k < 8; k++) begin
            if (k == 4) f_ack = 1'b0;
            send_word(dw(k), 1'b0, 3'd0);
        end
        check("c86_not_ready_yet", 1152'(out_ready), 1152'(1'b0));
        w8 = dw(8);
        send_word(w8, 1'b1, 3'd7);
        check("c86_ordy", 1152'(out_ready), 1152'(1'b1));
        check("c86_bf", 1152'(buffer_full), 1152'(1'b1));
        exp = '0;
        for (int k = 0; k < 8; k++) exp[1151-64*k -: 64] = dw(k);
        exp[639 -: 64] = {w8[63:8], 8'h86};
        check("c86_block", out, exp);

        // Multi-block with mode toggling and backpressure, SHA3-512
        do_reset();
        n_acc = 0;
        mode  = 2'd3;
        for (int k = 0; k < 9; k++) begin
            if (k == 3) mode = 2'd0;
            if (k == 6) mode = 2'd2;
            send_word(dw(k), 1'b0, 3'd0);
        end
        check("mb_blk1_ordy", 1152'(out_ready), 1152'(1'b1));
        exp = '0;
        for (int k = 0; k < 9; k++) exp[1151-64*k -: 64] = dw(k);
        check("mb_blk1", out, exp);
        in       = dw(9);
        in_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step();
            check("mb_hold_bf", 1152'(buffer_full), 1152'(1'b1));
            check("mb_hold_out", out, exp);
        end
        f_ack = 1'b1;
        step();
        f_ack = 1'b0;
        check("mb_ack_ordy", 1152'(out_ready), 1152'(1'b0));
        check("mb_ack_bf", 1152'(buffer_full), 1152'(1'b0));
        check("mb_ack_out", out, '0);
        step();
        in_ready = 1'b0;
        n_acc++;
        check("mb_w10_bf", 1152'(buffer_full), 1152'(1'b0));
        mode = 2'd1;
        send_word(64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 3'd0);
        n = 0;
        while (!out_ready && n < 40) begin
            step();
            n++;
        end
        check("mb_pad_cycles", 1152'(n), 1152'(7));
        exp = '0;
        exp[1151 -: 64] = dw(9);
        exp[1087 -: 64] = 64'h0600_0000_0000_0000;
        exp[583:576]    = 8'h80;
        check("mb_blk2", out, exp);
        check("mb_words_accepted", 1152'(n_acc), 1152'(11));
        f_ack = 1'b1;
        step();
        f_ack = 1'b0;
        check("mb_done_bf", 1152'(buffer_full), 1152'(1'b1));
        check("mb_done_ordy", 1152'(out_ready), 1152'(1'b0));

        // Mid-block reset, then empty SHA3-224 message
        do_reset();
        mode = 2'd2;
        for (int k = 0; k < 5; k++) send_word(dw(20 + k), 1'b0, 3'd0);
        do_reset();
        check("mr_rst_ordy", 1152'(out_ready), 1152'(1'b0));
        check("mr_rst_bf", 1152'(buffer_full), 1152'(1'b0));
        check("mr_rst_out", out, '0);
        mode = 2'd0;
        send_word(64'h0123_4567_89AB_CDEF, 1'b1, 3'd0);
        n = 0;
        while (!out_ready && n < 40) begin
            step();
            n++;
        end
        check("mr_pad_cycles", 1152'(n), 1152'(17));
        exp = '0;
        exp[1151:1144] = 8'h06;
        exp[7:0]       = 8'h80;
        check("mr_block", out, exp);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sha3_padder_mr.md
# sha3_padder_mr

Multi-rate SHA-3 input padder: the parametrised successor of the fixed-rate 576-bit padder. It accepts message words of configurable width, applies SHA-3 domain padding (0x06 … 0x80), and assembles rate blocks for any of SHA3-224/256/384/512, selected per message. It sits between the user interface and a Keccak-f[1600] permutation. It presents one left-aligned rate block at a time and waits for `f_ack` before absorbing further input.

## Interface
- `IN_W`, 64: message word width in bits; legal values 32 or 64.
- `BN_W`, `$clog2(IN_W/8)`: width of `byte_num`.
- `clk` input 1: clock; all state updates on its rising edge.
- `reset` input 1: synchronous, active-high reset.
- `in` input IN_W: message word; first byte in `in[IN_W-1 -: 8]`.
- `in_ready` input 1: `in` valid this cycle.
- `is_last` input 1: `in` is the final word; only meaningful with `in_ready`=1.
- `byte_num` input BN_W: number of valid bytes in the final word, 0…IN_W/8-1.
- `mode` input 2: 0=SHA3-224 (rate 1152), 1=SHA3-256 (1088), 2=SHA3-384 (832), 3=SHA3-512 (576).
- `buffer_full` output 1: user must hold `in`; a word is accepted only when this is 0.
- `out` output 1152: rate block, left-aligned in `out[1151 -: rate]`; bits below the rate read 0.
- `out_ready` output 1: `out` holds a complete block.
- `f_ack` input 1: permutation consumed `out`.

## Operation
- Words per block: `NW = rate/IN_W`. For IN_W=64: 18/17/13/9. For IN_W=32: 36/34/26/18.
- The block accumulates in a shift register: `buf <= {buf, word}` truncated to the rate, so the first word lands at the top. A word counter `cnt` counts 0…NW-1.
- FSM states:
  - IDLE: no message started.
  - ABSORB: taking user words.
  - PAD: self-filling after the last word.
  - FULL: block waiting for `f_ack`.
  - DONE: message fully absorbed.
- Reset (any state, including mid-block): state=IDLE, `cnt`=0, `buf`=0, `out_ready`=0, `buffer_full`=0, and the "last seen" flag is cleared.
- `mode` is latched into `mode_q` on the first accepted word of a message. Later changes to `mode` are ignored until reset.
- Accept condition: `in_ready && !buffer_full` in IDLE or ABSORB.
- Non-last word: shift in, `cnt++`. If `cnt` reaches NW, go to FULL.
- Last word: the shifted word is the `byte_num` valid bytes, then 0x06, then 0x00 bytes; set the last flag.
  - If this fills the block, the block's final byte is OR'd with 0x80 (0x86 when it coincides with the 0x06 byte) → FULL.
  - Otherwise → PAD.
- PAD: shifts one zero word per cycle, ignoring `in`. The final word of the block has its low byte = 0x80. → FULL.
- FULL: `out_ready`=1, `buffer_full`=1. On `f_ack`:
  - `buf`=0, `cnt`=0.
  - If the last flag is set → DONE, else → ABSORB.
- DONE: `buffer_full`=1, `out_ready`=0 until reset.
- `buffer_full` = 1 in PAD, FULL and DONE; 0 in IDLE and ABSORB.
- A full message whose length is a multiple of IN_W/8 bytes ends with an `is_last` word with `byte_num`=0. That word pads as 0x06 0x00… as usual.

## Timing
- Registered outputs only; no combinational path from `in`/`in_ready` to `buffer_full` or `out_ready`.
- The word that completes a block at edge N gives `out_ready`=1 after edge N.
- PAD adds one cycle per zero word.
- `f_ack` at edge M gives `out_ready`=0 and `buffer_full`=0 (if not last) after edge M. The next word can be accepted at edge M+1.
- `f_ack` when `out_ready`=0 is ignored.
- `in_ready` while `buffer_full`=1: the word is not consumed and the user holds it.

## Structure
- Package `sha3_pkg`:
  - mode encodings;
  - `RATE[4]` constants;
  - function `words_per_block(mode, IN_W)`;
  - `PAD_START`=8'h06, `PAD_END`=8'h80;
  - FSM state enum.
- Sub-module `sha3_pad_word`: combinational; builds the padded final word from `in`, `byte_num` and the "is final word of block" flag. It is reused for the PAD zero-word/0x80 case.

## Test plan
- Reset values: after reset, `out_ready`=0, `buffer_full`=0, `out`=0.
- Empty message, IN_W=64, mode=1: one `is_last` word with `byte_num`=0 → PAD for 16 cycles, then `out[1151:1144]`=0x06, `out[71:64]`=0x80, all else 0, `out_ready`=1. `f_ack` → DONE with `buffer_full`=1.
- 0x86 corner, mode=3, IN_W=64: 8 full words, then `is_last` with `byte_num`=7 → last word `{7 data bytes, 0x86}`, FULL with no PAD cycles.
- Multi-block, mode=3: 10 full words then `is_last`/`byte_num`=0.
  - First block is the 9 words; `buffer_full` stays high until `f_ack`.
  - Word 10 is accepted the cycle after `f_ack`.
  - Second block = word10, 0x06…, 0x80 low byte.
- Mode latch and backpressure: `mode` toggled mid-message → rate unchanged. `in_ready` held during FULL → no word lost or duplicated; verify with byte-count scoreboard.
- Mid-block reset: reset after 5 words → IDLE. A new empty message with mode=0 produces the correct 1152-bit padded block.
